din_debounce_pulse: RTL and testbench

DIN_DEBOUNCE_PULSE -- requirements
Module: din_debounce_pulse

---
 rtl/din_debounce_pulse.sv | 87 ++++++++
 tb/tb_din_debounce_pulse.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/din_debounce_pulse.sv
// Debounces a raw asynchronous level through a 2-flop synchronizer and a
// 4-state stability FSM; emits a one-cycle strobe and a wrapping count per accepted rise.
module din_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       din_pulse,
  output logic       level,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  state_t      state;
  logic        sync1, sync2;
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      state       <= LOW;
      cnt         <= 16'd0;
      din_pulse   <= 1'b0;
      level       <= 1'b0;
      press_count <= 8'd0;
    end else begin
      sync1     <= btn_in;
      sync2     <= sync1;
      din_pulse <= 1'b0;
      case (state)
        LOW: begin
          if (sync2) begin
            state <= RISE_WAIT;
            cnt   <= 16'd0;
          end
        end
        RISE_WAIT: begin
          if (!sync2) begin
            state <= LOW;
            cnt   <= 16'd0;
          end else if (cnt == CNT_LAST) begin
            state       <= HIGH;
            level       <= 1'b1;
            din_pulse   <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HIGH: begin
          if (!sync2) begin
            state <= FALL_WAIT;
            cnt   <= 16'd0;
          end
        end
        FALL_WAIT: begin
          // A bounce back to 1 returns to HIGH silently; only RISE_WAIT->HIGH strobes.
          if (sync2) begin
            state <= HIGH;
            cnt   <= 16'd0;
          end else if (cnt == CNT_LAST) begin
            state <= LOW;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= 16'd0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_din_debounce_pulse.sv
// Bench for din_debounce_pulse: vector table, directed corner sequences, and
// randomized bouncing checked against a run-length debounce model.
module tb_din_debounce_pulse;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       din_pulse;
  logic       level;
  logic [7:0] press_count;

  din_debounce_pulse #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .din_pulse(din_pulse), .level(level), .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       b;
    logic       pulse;
    logic       lvl;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;
  int   pulses_seen = 0;

  // Model: a level flips once the synchronized input has disagreed with it
  // for N+1 consecutive edges; any agreeing sample restarts the run.
  logic       m_s1 = 0, m_s2 = 0, m_level = 0, m_pulse = 0;
  int         m_run = 0;
  logic [7:0] m_cnt = 0;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got pulse/level/count=%h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] outs();
    return {din_pulse, level, press_count};
  endfunction

  task automatic step(input logic r, input logic b);
    rst = r;
    btn_in = b;
    @(posedge clk);
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_run = 0; m_cnt = 0;
    end else begin
      m_pulse = 0;
      if (m_s2 !== m_level) m_run++;
      else m_run = 0;
      if (m_run == N + 1) begin
        m_level = m_s2;
        m_run = 0;
        if (m_level) begin
          m_pulse = 1;
          m_cnt++;
        end
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
    #1;
    chk("model", outs(), {m_pulse, m_level, m_cnt});
    if (din_pulse) pulses_seen++;
  endtask

  function automatic vec_t mk(input logic r, input logic b, input logic p,
                              input logic l, input logic [7:0] c);
    vec_t v;
    v.r = r; v.b = b; v.pulse = p; v.lvl = l; v.cnt = c;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    btn_in = 1'b0;

    // Reset, idle, clean press from edge 22 (pulse after edge 28), release from edge 32.
    for (int i = 0; i < 2; i++)  tbl.push_back(mk(1, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) tbl.push_back(mk(0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)  tbl.push_back(mk(0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1));
    for (int i = 0; i < 3; i++)  tbl.push_back(mk(0, 1, 0, 1, 1));
    for (int i = 0; i < 6; i++)  tbl.push_back(mk(0, 0, 0, 1, 1));
    for (int i = 0; i < 2; i++)  tbl.push_back(mk(0, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].b);
      chk($sformatf("tbl[%0d]", i), outs(), {tbl[i].pulse, tbl[i].lvl, tbl[i].cnt});
    end

    // Glitch: three high samples never reach acceptance.
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      chk("glitch_hi", outs(), {1'b0, 1'b0, 8'd1});
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      chk("glitch_lo", outs(), {1'b0, 1'b0, 8'd1});
    end

    // Second press to reach HIGH.
    for (int i = 0; i < 8; i++) step(0, 1);
    chk("press2", outs(), {1'b0, 1'b1, 8'd2});

    // Release bounce: level holds, no strobe on FALL_WAIT->HIGH.
    for (int i = 0; i < 2; i++) begin
      step(0, 0);
      chk("bounce_lo", outs(), {1'b0, 1'b1, 8'd2});
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1);
      chk("bounce_hi", outs(), {1'b0, 1'b1, 8'd2});
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0);
      chk($sformatf("release[%0d]", i), outs(), {1'b0, (i < 6) ? 1'b1 : 1'b0, 8'd2});
    end

    // Reset mid-rise, button held through and after reset.
    for (int i = 0; i < 4; i++) step(0, 1);
    step(1, 1);
    chk("rst_mid_rise", outs(), 10'd0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1);
      chk($sformatf("post_rst[%0d]", i), outs(),
          (i == 6) ? {1'b1, 1'b1, 8'd1} : (i < 6) ? 10'd0 : {1'b0, 1'b1, 8'd1});
    end
    for (int i = 0; i < 8; i++) step(0, 0);

    // Random bouncing with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic b;
      int   len;
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) step(($urandom_range(0, 99) == 0), b);
    end

    // Wrap: 256 clean press/release cycles.
    step(1, 0);
    pulses_seen = 0;
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 8; i++) step(0, 1);
      for (int i = 0; i < 8; i++) step(0, 0);
    end
    chk("wrap_pulses", 10'(pulses_seen), 10'd256);
    chk("wrap_count", {2'b00, press_count}, 10'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
